// File: rtl/crc32_stream_engine.sv
// Streaming Ethernet CRC-32 engine: one-stage register slice that appends the FCS
// (generate mode) or verifies it by residue (check mode) on 1, 2 or 4 byte lanes.
module crc32_stream_engine #(
  parameter int          DW_BYTES = 4,
  parameter logic [31:0] RESIDUE  = 32'hDEBB20E3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic                    abort,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*DW_BYTES-1:0]   s_data,
  input  logic [DW_BYTES-1:0]     s_keep,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [8*DW_BYTES-1:0]   m_data,
  output logic [DW_BYTES-1:0]     m_keep,
  output logic                    m_last,
  output logic [31:0]             crc_out,
  output logic                    crc_valid,
  output logic                    crc_ok
);
  localparam int          DW_BITS   = 8 * DW_BYTES;
  localparam int          FCS_BEATS = 4 / DW_BYTES;
  localparam logic [1:0]  LAST_IDX  = 2'(FCS_BEATS - 1);
  localparam logic [31:0] POLY      = 32'hEDB88320;

  typedef enum logic {ST_DATA, ST_FCS} state_t;

  state_t             state;
  logic [31:0]        crc_reg;
  logic [1:0]         fcs_idx;
  logic               fcs_sent;
  logic               in_frame;
  logic               mode_reg;
  logic               out_free;
  logic               accept;
  logic               cur_mode;
  logic [31:0]        crc_next;
  logic [31:0]        fcs_word;
  logic [DW_BITS-1:0] fcs_beat;

  // Folds the enabled lanes of one beat into the reflected CRC, lane 0 first.
  function automatic logic [31:0] crc_fold(input logic [31:0] crc,
                                           input logic [DW_BITS-1:0] data,
                                           input logic [DW_BYTES-1:0] keep);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < DW_BYTES; i++) begin
      if (keep[i]) begin
        c = c ^ {24'd0, data[8*i +: 8]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      end
    end
    return c;
  endfunction

  assign out_free = !m_valid || m_ready;
  assign s_ready  = (state == ST_DATA) && out_free;
  assign accept   = s_valid && s_ready;
  assign cur_mode = in_frame ? mode_reg : mode;
  assign crc_next = crc_fold(crc_reg, s_data, s_keep);
  assign fcs_word = ~crc_reg;
  assign fcs_beat = DW_BITS'(fcs_word >> (32'(fcs_idx) * DW_BITS));

  // Stage p0 -> p1: register slice, CRC register and frame FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_DATA;
      crc_reg   <= '1;
      fcs_idx   <= '0;
      fcs_sent  <= 1'b0;
      in_frame  <= 1'b0;
      mode_reg  <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_keep    <= '0;
      m_last    <= 1'b0;
      crc_out   <= '0;
      crc_valid <= 1'b0;
      crc_ok    <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (m_ready) m_valid <= 1'b0;
      case (state)
        ST_DATA: begin
          if (accept) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_keep  <= s_keep;
            m_last  <= s_last;
          end
          // An aborted beat is still forwarded but never reaches the CRC.
          if (abort) begin
            crc_reg  <= '1;
            in_frame <= 1'b0;
          end else if (accept) begin
            if (!in_frame) mode_reg <= mode;
            if (s_last) begin
              in_frame <= 1'b0;
              if (cur_mode) begin
                crc_reg   <= '1;
                crc_out   <= ~crc_next;
                crc_ok    <= (crc_next == RESIDUE);
                crc_valid <= 1'b1;
              end else begin
                m_last   <= 1'b0;
                crc_reg  <= crc_next;
                fcs_idx  <= '0;
                fcs_sent <= 1'b0;
                state    <= ST_FCS;
              end
            end else begin
              in_frame <= 1'b1;
              crc_reg  <= crc_next;
            end
          end
        end
        ST_FCS: begin
          if (fcs_sent) begin
            if (m_ready) begin
              state     <= ST_DATA;
              crc_reg   <= '1;
              crc_out   <= fcs_word;
              crc_ok    <= 1'b0;
              crc_valid <= 1'b1;
            end
          end else if (out_free) begin
            m_valid <= 1'b1;
            m_data  <= fcs_beat;
            m_keep  <= '1;
            m_last  <= (fcs_idx == LAST_IDX);
            fcs_idx <= fcs_idx + 2'd1;
            if (fcs_idx == LAST_IDX) fcs_sent <= 1'b1;
          end
        end
        default: state <= ST_DATA;
      endcase
    end
  end
endmodule
